// File: rtl/alu_mem_unit.sv
// ---------------------------------------------------------------------------
// alu_mem_unit
//   Single-cycle ALU, ALU-control decoder and doubleword data memory, as used
//   in the execute/memory portion of a simple LEGv8-style datapath.
//
//   Parameters
//     MEM_WORDS   number of 64-bit doublewords in data memory (power of 2,
//                 2..256)
//
//   Ports
//     clk          in   1   rising-edge clock
//     reset        in   1   synchronous, active-high; clears memory
//     ALUOp        in   2   main-control ALU operation class
//     Opcode       in  11   instruction bits [31:21]
//     op1          in  64   ALU operand A
//     op2          in  64   ALU operand B
//     WriteData    in  64   store data
//     MemWrite     in   1   store enable
//     MemRead      in   1   load enable
//     ALU_Control  out  4   decoded ALU operation
//     ALU_Result   out 64   ALU result, also the memory byte address
//     zero         out  1   ALU_Result == 0
//     ReadData     out 64   combinational load data
// ---------------------------------------------------------------------------
module alu_mem_unit #(
    parameter int MEM_WORDS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  ALUOp,
    input  logic [10:0] Opcode,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    input  logic [63:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [3:0]  ALU_Control,
    output logic [63:0] ALU_Result,
    output logic        zero,
    output logic [63:0] ReadData
);

    localparam int IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_ORR   = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_SUB   = 4'b0110,
        ALU_PASSB = 4'b0111,
        ALU_NOR   = 4'b1100
    } alu_op_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;

    alu_op_e           w_ctrl;
    logic [63:0]       w_result;
    logic [IDX_W-1:0]  w_idx;
    logic              w_in_range;
    logic [63:0]       r_mem [MEM_WORDS];

    // ALU control decode. R-type opcodes outside the supported set fall back
    // to add, as does the unused ALUOp class 11.
    always_comb begin
        w_ctrl = ALU_ADD;
        case (ALUOp)
            2'b00: w_ctrl = ALU_ADD;
            2'b01: w_ctrl = ALU_PASSB;
            2'b10: begin
                case (Opcode)
                    OPC_ADD: w_ctrl = ALU_ADD;
                    OPC_SUB: w_ctrl = ALU_SUB;
                    OPC_AND: w_ctrl = ALU_AND;
                    OPC_ORR: w_ctrl = ALU_ORR;
                    default: w_ctrl = ALU_ADD;
                endcase
            end
            default: w_ctrl = ALU_ADD;
        endcase
    end

    assign ALU_Control = w_ctrl;

    // ALU. NOR is not reachable from the decoder but is kept so the ALU
    // honours the full control encoding if driven by another decoder later.
    always_comb begin
        w_result = 64'd0;
        case (w_ctrl)
            ALU_AND:   w_result = op1 & op2;
            ALU_ORR:   w_result = op1 | op2;
            ALU_ADD:   w_result = op1 + op2;
            ALU_SUB:   w_result = op1 - op2;
            ALU_PASSB: w_result = op2;
            ALU_NOR:   w_result = ~(op1 | op2);
            default:   w_result = 64'd0;
        endcase
    end

    assign ALU_Result = w_result;
    assign zero       = (w_result == 64'd0);

    // Byte address -> doubleword index; the low three bits are ignored and
    // any set bit above the index field makes the access out of range.
    assign w_idx      = w_result[IDX_W+2:3];
    assign w_in_range = ~|w_result[63:IDX_W+3];

    // Reset wins over a coincident store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                r_mem[i] <= 64'd0;
            end
        end else if (MemWrite && w_in_range) begin
            r_mem[w_idx] <= WriteData;
        end
    end

    // Asynchronous read: a simultaneous store shows the old word until the edge.
    assign ReadData = (MemRead && !reset && w_in_range) ? r_mem[w_idx] : 64'd0;

endmodule

// File: tb/tb_alu_mem_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_mem_unit
//   Self-checking bench for alu_mem_unit: directed cases followed by random
//   ALU and load/store traffic compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_alu_mem_unit;

    localparam int MW = 32;

    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [10:0] Opcode = 11'd0;
    logic [63:0] op1 = 64'd0;
    logic [63:0] op2 = 64'd0;
    logic [63:0] WriteData = 64'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [3:0]  ALU_Control;
    logic [63:0] ALU_Result;
    logic        zero;
    logic [63:0] ReadData;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] model_mem [MW];

    alu_mem_unit #(.MEM_WORDS(MW)) dut (
        .clk(clk), .reset(reset), .ALUOp(ALUOp), .Opcode(Opcode),
        .op1(op1), .op2(op2), .WriteData(WriteData), .MemWrite(MemWrite),
        .MemRead(MemRead), .ALU_Control(ALU_Control), .ALU_Result(ALU_Result),
        .zero(zero), .ReadData(ReadData)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Expected operation, described in terms of what the instruction means.
    function automatic logic [3:0] m_ctrl(input logic [1:0] aop, input logic [10:0] opc);
        if (aop == 2'b01) return 4'b0111;
        if (aop == 2'b10) begin
            if (opc == OP_SUB) return 4'b0110;
            if (opc == OP_AND) return 4'b0000;
            if (opc == OP_ORR) return 4'b0001;
        end
        return 4'b0010;
    endfunction

    function automatic logic [63:0] m_alu(input logic [1:0] aop, input logic [10:0] opc,
                                          input logic [63:0] a, input logic [63:0] b);
        if (aop == 2'b01) return b;
        if (aop == 2'b10) begin
            if (opc == OP_SUB) return a - b;
            if (opc == OP_AND) return a & b;
            if (opc == OP_ORR) return a | b;
        end
        return a + b;
    endfunction

    task automatic apply(input logic [1:0] aop, input logic [10:0] opc,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] wd, input logic mw, input logic mr,
                         input logic rst);
        ALUOp = aop; Opcode = opc; op1 = a; op2 = b;
        WriteData = wd; MemWrite = mw; MemRead = mr; reset = rst;
        #1;
    endtask

    // Check all outputs against the model before the edge, then clock once
    // and update the model.
    task automatic cycle(input string tag);
        logic [63:0] addr, res, rd;
        logic        inr;
        res  = m_alu(ALUOp, Opcode, op1, op2);
        addr = res;
        inr  = (addr / 8) < MW;
        rd   = (MemRead && !reset && inr) ? model_mem[addr / 8] : 64'd0;
        chk({tag, ".ctrl"}, {60'd0, ALU_Control}, {60'd0, m_ctrl(ALUOp, Opcode)});
        chk({tag, ".res"}, ALU_Result, res);
        chk({tag, ".zero"}, {63'd0, zero}, {63'd0, res == 64'd0});
        chk({tag, ".rd"}, ReadData, rd);
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < MW; i++) model_mem[i] = 64'd0;
        end else if (MemWrite && inr) begin
            model_mem[addr / 8] = WriteData;
        end
        #1;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < MW; i++) begin
            apply(2'b00, 11'd0, 64'(i * 8), 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
            chk(tag, ReadData, model_mem[i]);
        end
    endtask

    initial begin
        for (int i = 0; i < MW; i++) model_mem[i] = 64'd0;

        // Reset; ReadData must be 0 while reset is high.
        apply(2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b1);
        chk("rst.rd", ReadData, 64'd0);
        cycle("rst");

        // Directed ALU cases.
        apply(2'b10, OP_SUB, 64'd5, 64'd5, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("sub.ctrl", {60'd0, ALU_Control}, 64'h6);
        chk("sub.res", ALU_Result, 64'd0);
        chk("sub.zero", {63'd0, zero}, 64'd1);
        apply(2'b10, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("addwrap.res", ALU_Result, 64'd1);
        chk("addwrap.zero", {63'd0, zero}, 64'd0);
        apply(2'b10, OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("addzero.zero", {63'd0, zero}, 64'd1);
        apply(2'b10, OP_AND, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("and.res", ALU_Result, 64'hF000);
        apply(2'b10, OP_ORR, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("orr.res", ALU_Result, 64'hFFF0);
        apply(2'b01, 11'd0, 64'h1234, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("cbz.res", ALU_Result, 64'd0);
        chk("cbz.zero", {63'd0, zero}, 64'd1);
        apply(2'b11, OP_SUB, 64'd3, 64'd4, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("aop11.ctrl", {60'd0, ALU_Control}, 64'h2);
        // ALU is unaffected by reset.
        apply(2'b10, OP_ORR, 64'hF0F0, 64'hFF00, 64'd0, 1'b0, 1'b0, 1'b1);
        chk("rst.alu", ALU_Result, 64'hFFF0);
        cycle("rstalu");

        // Load/store sequence.
        apply(2'b00, 11'd0, 64'd16, 64'd8, 64'h1234_5678, 1'b1, 1'b0, 1'b0);
        cycle("st24");
        apply(2'b00, 11'd0, 64'd16, 64'd8, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("ld24", ReadData, 64'h1234_5678);
        cycle("ld24m");
        apply(2'b00, 11'd0, 64'd32, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("ld32", ReadData, 64'd0);

        // Simultaneous read/write to word 3.
        apply(2'b00, 11'd0, 64'd24, 64'd0, 64'hAA, 1'b1, 1'b0, 1'b0);
        cycle("stAA");
        apply(2'b00, 11'd0, 64'd24, 64'd0, 64'hBB, 1'b1, 1'b1, 1'b0);
        chk("rw.pre", ReadData, 64'hAA);
        cycle("rw");
        chk("rw.post", ReadData, 64'hBB);

        // Out-of-range store leaves memory alone; low address bits ignored.
        apply(2'b00, 11'd0, 64'h1_0000_0000, 64'd0, 64'hDEAD, 1'b1, 1'b0, 1'b0);
        cycle("oor");
        apply(2'b00, 11'd0, 64'd3, 64'd2, 64'h77, 1'b1, 1'b0, 1'b0);
        cycle("unal");
        apply(2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("unal.rd", ReadData, 64'h77);
        read_all("oor.all");

        // Reset beats a coincident store.
        apply(2'b00, 11'd0, 64'd8, 64'd0, 64'h55, 1'b1, 1'b1, 1'b1);
        cycle("rstwr");
        read_all("rstwr.all");

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            logic [1:0]  aop;
            logic [10:0] opc;
            logic [63:0] a, b;
            int          kind;
            kind = $urandom_range(0, 9);
            if (kind < 5) begin
                // memory access, mostly in range
                aop = 2'b00; opc = 11'($urandom);
                a = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                                : 64'($urandom_range(0, MW * 8 + 15));
                b = 64'($urandom_range(0, 7));
            end else begin
                aop = 2'($urandom);
                case ($urandom_range(0, 4))
                    0: opc = OP_ADD;
                    1: opc = OP_SUB;
                    2: opc = OP_AND;
                    3: opc = OP_ORR;
                    default: opc = 11'($urandom);
                endcase
                a = {$urandom, $urandom};
                b = ($urandom_range(0, 3) == 0) ? a : {$urandom, $urandom};
                if ($urandom_range(0, 7) == 0) b = 64'd0;
            end
            apply(aop, opc, a, b, {$urandom, $urandom}, 1'($urandom), 1'($urandom),
                  $urandom_range(0, 39) == 0);
            cycle("rnd");
        end
        read_all("final.all");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
